// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multicycle MIPS main controller.
// Contents: opcode/funct constants, alucontrol codes, alusrcb/pcsrc mux
// encodings and the controller state enum.
package mips_mc_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: combinational R-type funct decoder.
// Ports:
//   funct       in  6  instruction bits [5:0]
//   alucontrol  out 3  ALU operation for this funct
//   funct_valid out 1  1 when funct is one of add/sub/and/or/slt
module mips_alu_dec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: Moore-style multicycle main controller for the MIPS
// core. Sequences each instruction through fetch/decode/execute states,
// handshakes with instruction and data RAM (req held until ack), counts
// retired instructions and flags undecodable instructions.
// Ports:
//   clk, rst (async, active-low)
//   opcode, funct, zero        instruction fields and ALU zero flag
//   inst_ack, data_ack         memory completion handshakes
//   inst_ram_ena, data_ram_ena, data_ram_wea   memory requests
//   pc_we, ir_we, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc,
//   alucontrol                 datapath controls
//   instret                    retired-instruction counter (wraps)
//   illegal                    one-cycle pulse on undecodable instruction
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              inst_ack,
    input  logic              data_ack,
    output logic              inst_ram_ena,
    output logic              data_ram_ena,
    output logic              data_ram_wea,
    output logic              pc_we,
    output logic              ir_we,
    output logic              regwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              illegal,
    output logic [CNT_W-1:0]  instret
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic [2:0]       w_alu_fn;
    logic             w_funct_valid;

    mips_alu_dec u_alu_dec (
        .funct       (funct),
        .alucontrol  (w_alu_fn),
        .funct_valid (w_funct_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign instret = r_instret;

    // NOTE: every output is given a default before the case so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        inst_ram_ena = 1'b0;
        data_ram_ena = 1'b0;
        data_ram_wea = 1'b0;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_RT;
        pcsrc        = PC_ALU;
        alucontrol   = '0;
        illegal      = 1'b0;

        case (r_state)
            S_IDLE: w_next_state = S_FETCH;

            S_FETCH: begin
                inst_ram_ena = 1'b1;
                alusrcb      = SRCB_FOUR;
                alucontrol   = ALUC_W'(ALU_ADD);
                // IR and PC+4 are captured only on the ack cycle.
                ir_we        = inst_ack;
                pc_we        = inst_ack;
                if (inst_ack) w_next_state = S_DECODE;
            end

            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alusrcb    = SRCB_IMMSH;
                alucontrol = ALUC_W'(ALU_ADD);
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca      = 1'b1;
                alusrcb      = SRCB_IMM;
                alucontrol   = ALUC_W'(ALU_ADD);
                w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                data_ram_ena = 1'b1;
                if (data_ack) w_next_state = S_MEMWB;
            end

            S_MEMWB: begin
                regwrite     = 1'b1;
                memtoreg     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEMWR: begin
                data_ram_ena = 1'b1;
                data_ram_wea = 1'b1;
                if (data_ack) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_EXEC: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = ALUC_W'(w_alu_fn);
                illegal    = !w_funct_valid;
                w_next_state = w_funct_valid ? S_ALUWB : S_FETCH;
            end

            S_ALUWB: begin
                regwrite     = 1'b1;
                regdst       = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_BRANCH: begin
                alusrca      = 1'b1;
                alusrcb      = SRCB_RT;
                alucontrol   = ALUC_W'(ALU_SUB);
                pcsrc        = PC_ALUOUT;
                pc_we        = zero;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = SRCB_IMM;
                alucontrol   = ALUC_W'(ALU_ADD);
                w_next_state = S_ADDIWB;
            end

            S_ADDIWB: begin
                regwrite     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_JUMP: begin
                pcsrc        = PC_JUMP;
                pc_we        = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed bench for the multicycle controller.
// All inputs change and outputs are sampled 1 ns after the falling edge.
// The DUT uses CNT_W=4 so the counter wrap is reachable quickly.
module tb_mips_mc_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        inst_ack = 1'b0;
    logic        data_ack = 1'b0;
    logic        inst_ram_ena, data_ram_ena, data_ram_wea, pc_we, ir_we;
    logic        regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  instret;

    logic [16:0] ctl;
    logic [16:0] e;
    logic [3:0]  exp_ir;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mips_mc_controller #(.CNT_W(4), .ALUC_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .inst_ack     (inst_ack),
        .data_ack     (data_ack),
        .inst_ram_ena (inst_ram_ena),
        .data_ram_ena (data_ram_ena),
        .data_ram_wea (data_ram_wea),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .regwrite     (regwrite),
        .regdst       (regdst),
        .memtoreg     (memtoreg),
        .alusrca      (alusrca),
        .alusrcb      (alusrcb),
        .pcsrc        (pcsrc),
        .alucontrol   (alucontrol),
        .illegal      (illegal),
        .instret      (instret)
    );

    assign ctl = {inst_ram_ena, data_ram_ena, data_ram_wea, pc_we, ir_we,
                  regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc,
                  alucontrol, illegal};

    // Packs an expected control vector in the same order as ctl.
    function automatic logic [16:0] mk(
        input logic ireq, dreq, wea, pcwe, irwe, rw, rd, m2r, sa,
        input logic [1:0] sb, ps, input logic [2:0] ac, input logic ill);
        return {ireq, dreq, wea, pcwe, irwe, rw, rd, m2r, sa, sb, ps, ac, ill};
    endfunction

    // Advance to the next cycle, apply acks, let combinational outputs settle.
    task automatic cyc(input logic ia, input logic da);
        @(negedge clk);
        inst_ack = ia;
        data_ack = da;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ctl !== 17'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", ctl); end
        checks++;
        if (instret !== 4'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 17'd0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", ctl); end
        cyc(0, 0);
        e = mk(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL first_fetch got=%h exp=%h", ctl, e); end
        exp_ir = 4'd0;
    endtask

    task automatic test_rtype;
        logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ac_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            opcode = 6'b000000;
            funct  = fn_tab[i];
            cyc(1, 0);
            e = mk(1,0,0,1,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL rtype%0d_fetch got=%h exp=%h", i, ctl, e); end
            cyc(0, 0);
            e = mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL rtype%0d_decode got=%h exp=%h", i, ctl, e); end
            cyc(0, 0);
            e = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, ac_tab[i], 0);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL rtype%0d_exec got=%h exp=%h", i, ctl, e); end
            cyc(0, 0);
            e = mk(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 0);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL rtype%0d_aluwb got=%h exp=%h", i, ctl, e); end
            #5;
            exp_ir++;
            checks++;
            if (instret !== exp_ir) begin failures++; $display("FAIL rtype%0d_instret got=%0d exp=%0d", i, instret, exp_ir); end
        end
    endtask

    task automatic test_lw_wait;
        int n_ena = 0;
        opcode = 6'b100011;
        cyc(1, 0);
        cyc(0, 0);
        // data_ack while no data request is pending must be ignored
        cyc(0, 1);
        e = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL lw_memadr got=%h exp=%h", ctl, e); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, k == 2);
            if (data_ram_ena) n_ena++;
            e = mk(0,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL lw_memrd%0d got=%h exp=%h", k, ctl, e); end
        end
        cyc(0, 0);
        if (data_ram_ena) n_ena++;
        e = mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL lw_memwb_cycle7 got=%h exp=%h", ctl, e); end
        checks++;
        if (n_ena !== 3) begin failures++; $display("FAIL lw_ena_cycles got=%0d exp=3", n_ena); end
        #5;
        exp_ir++;
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL lw_instret got=%0d exp=%0d", instret, exp_ir); end
    endtask

    task automatic test_sw;
        opcode = 6'b101011;
        cyc(0, 0);
        e = mk(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL sw_fetch_wait got=%h exp=%h", ctl, e); end
        cyc(1, 0);
        e = mk(1,0,0,1,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL sw_fetch_ack got=%h exp=%h", ctl, e); end
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 1);
        e = mk(0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL sw_memwr got=%h exp=%h", ctl, e); end
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL sw_instret_pre got=%0d exp=%0d", instret, exp_ir); end
        #5;
        exp_ir++;
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL sw_instret got=%0d exp=%0d", instret, exp_ir); end
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100;
            zero   = 1'(z);
            cyc(1, 0);
            cyc(0, 0);
            cyc(0, 0);
            e = mk(0,0,0,1'(z),0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL beq_z%0d got=%h exp=%h", z, ctl, e); end
            #5;
            exp_ir++;
            checks++;
            if (instret !== exp_ir) begin failures++; $display("FAIL beq_z%0d_instret got=%0d exp=%0d", z, instret, exp_ir); end
        end
        zero = 1'b0;
    endtask

    task automatic test_addi_jump;
        opcode = 6'b001000;
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        e = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL addi_ex got=%h exp=%h", ctl, e); end
        cyc(0, 0);
        e = mk(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL addi_wb got=%h exp=%h", ctl, e); end
        #5;
        exp_ir++;
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL addi_instret got=%0d exp=%0d", instret, exp_ir); end
        opcode = 6'b000010;
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        e = mk(0,0,0,1,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL jump got=%h exp=%h", ctl, e); end
        #5;
        exp_ir++;
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL jump_instret got=%0d exp=%0d", instret, exp_ir); end
    endtask

    task automatic test_illegal;
        opcode = 6'b111111;
        cyc(1, 0);
        cyc(0, 0);
        e = mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 1);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_op_decode got=%h exp=%h", ctl, e); end
        cyc(0, 0);
        e = mk(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_op_refetch got=%h exp=%h", ctl, e); end
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL ill_op_instret got=%0d exp=%0d", instret, exp_ir); end
        opcode = 6'b000000;
        funct  = 6'b000111;
        cyc(1, 0);
        cyc(0, 0);
        checks++;
        if (illegal !== 1'b0) begin failures++; $display("FAIL ill_fn_decode_illegal got=%b exp=0", illegal); end
        cyc(0, 0);
        checks++;
        if ({illegal, regwrite} !== 2'b10) begin failures++; $display("FAIL ill_fn_exec got=%b exp=10", {illegal, regwrite}); end
        cyc(0, 0);
        e = mk(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_fn_refetch got=%h exp=%h", ctl, e); end
        checks++;
        if (instret !== exp_ir) begin failures++; $display("FAIL ill_fn_instret got=%0d exp=%0d", instret, exp_ir); end
    endtask

    task automatic test_reset_wrap;
        opcode = 6'b100011;
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        checks++;
        if (data_ram_ena !== 1'b1) begin failures++; $display("FAIL midrst_memrd_ena got=%b exp=1", data_ram_ena); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 17'd0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", ctl); end
        checks++;
        if (instret !== 4'd0) begin failures++; $display("FAIL midrst_instret got=%0d exp=0", instret); end
        exp_ir = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 17'd0) begin failures++; $display("FAIL midrst_idle got=%h exp=0", ctl); end
        opcode = 6'b000010;
        for (int n = 1; n <= 17; n++) begin
            cyc(1, 0);
            cyc(0, 0);
            cyc(0, 0);
            #5;
            exp_ir++;
            checks++;
            if (instret !== exp_ir) begin failures++; $display("FAIL wrap_%0d got=%0d exp=%0d", n, instret, exp_ir); end
        end
        checks++;
        if (instret !== 4'd1) begin failures++; $display("FAIL wrap_final got=%0d exp=1", instret); end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_lw_wait;
        test_sw;
        test_beq;
        test_addi_jump;
        test_illegal;
        test_reset_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle main controller for the next-generation MIPS core, replacing the single-cycle combinational decoder. It sequences each instruction through a Moore FSM, drives the shared-ALU datapath control lines, and waits on req/ack handshakes to instruction and data RAM, so memories with arbitrary wait states are supported. It sits beside the multicycle datapath inside the `mips` top and also exports an instruction-retired counter and an illegal-instruction pulse.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `ALUC_W`, 3: width of `alucontrol`.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `opcode  in  6`: instruction bits [31:26], from the instruction register.
- `funct  in  6`: instruction bits [5:0].
- `zero  in  1`: ALU zero flag.
- `inst_ack  in  1`: instruction RAM read data valid.
- `data_ack  in  1`: data RAM access complete.
- `inst_ram_ena  out  1`: instruction fetch request.
- `data_ram_ena  out  1`: data access request.
- `data_ram_wea  out  1`: data write; valid only with `data_ram_ena`.
- `pc_we  out  1`: PC load.
- `ir_we  out  1`: instruction register load.
- `regwrite  out  1`: register-file write.
- `regdst  out  1`: 1 = rd, 0 = rt.
- `memtoreg  out  1`: 1 = memory data to register file.
- `alusrca  out  1`: 0 = PC, 1 = rs.
- `alusrcb  out  2`: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2.
- `pcsrc  out  2`: 00 ALU result, 01 ALUOut register, 10 jump target.
- `alucontrol  out  ALUC_W`: add 010, sub 110, and 000, or 001, slt 111.
- `instret  out  CNT_W`: retired-instruction count.
- `illegal  out  1`: one-cycle pulse on an undecodable instruction.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- IDLE: all outputs 0. Go to FETCH on the next edge.
- FETCH:
  - Drive `inst_ram_ena`=1, `alusrca`=0, `alusrcb`=01, `alucontrol`=add, `pcsrc`=00.
  - On the `inst_ack`=1 cycle, pulse `ir_we` and `pc_we` (PC+4) and go to DECODE. Otherwise hold.
- DECODE: `alusrca`=0, `alusrcb`=11, add (branch target into ALUOut). Dispatch on opcode:
  - 100011 lw / 101011 sw → MEMADR
  - 000000 R-type → EXEC
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEX
  - 000010 j → JUMP
  - any other opcode → `illegal` pulse, FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD:
  - `data_ram_ena`=1, hold until `data_ack`, then MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Retire, go to FETCH.
- MEMWR:
  - `data_ram_ena`=1, `data_ram_wea`=1, hold until `data_ack`. Retire on the ack cycle, go to FETCH.
- EXEC: `alusrca`=1, `alusrcb`=00. `alucontrol` from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct: `illegal` pulse, no ALUWB, go to FETCH.
- ALUWB: `regwrite`=1, `regdst`=1, `memtoreg`=0. Retire.
- BRANCH: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, `pc_we`=`zero`. Retire.
- ADDIEX: `alusrca`=1, `alusrcb`=10, add, then ADDIWB.
- ADDIWB: `regwrite`=1, `regdst`=0. Retire.
- JUMP: `pcsrc`=10, `pc_we`=1. Retire.
- Illegal instructions leave PC at PC+4 (NOP semantics) and do not retire.
- `instret` increments by 1 per retire and wraps modulo 2^CNT_W.
- Acks arriving while the matching request is low are ignored.

## Timing
- Reset value of every output is 0, `instret`=0, state=IDLE.
- Asynchronous assertion of `rst` forces IDLE immediately, including mid-handshake; requests drop combinationally.
- Outputs are decoded combinationally from state, plus the ack-qualified writes in FETCH and MEMWR.
- With zero-wait memory (ack in the first request cycle):
  - R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each memory wait cycle adds exactly 1.
- A request stays asserted, with address/control stable, until the ack cycle inclusive. It deasserts on the following edge.

## Structure
- `mips_mc_pkg`: opcode and funct constants, alucontrol codes, alusrcb/pcsrc encodings, state enum.
- Sub-module `mips_alu_dec`: combinational funct → {`alucontrol`, funct_valid}, used in EXEC.

## Test plan
- Reset: hold `rst`=0 → all outputs 0, `instret`=0. After release: one IDLE cycle, then `inst_ram_ena`=1.
- add (opcode 000000, funct 100000), acks immediate → `regwrite`/`regdst` high in cycle 4, `instret`=1.
- lw, `data_ack` delayed 2 cycles → `data_ram_ena` high exactly 3 cycles, `regwrite`+`memtoreg` in cycle 7.
- beq with `zero`=1 → `pc_we`=1, `pcsrc`=01 in cycle 3. With `zero`=0 → `pc_we`=0; `instret` increments in both cases.
- opcode 111111, and R-type funct 000111 → single `illegal` pulse, no `regwrite`, `instret` unchanged, back to FETCH.
- Mid-access reset: assert `rst` during MEMRD → `data_ram_ena` drops that cycle. With `CNT_W`=4, 17 retires → `instret`=1.
